// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and saturating debug counters.
// Latency: one cycle ID->EX; stall is combinational from the EX register and the ID fields.
// Backpressure: a load-use hazard raises stall (hold PC/IF-ID) and inserts a bubble; flush overrides stall.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_branch_eq,
    input  logic             id_branch_ne,
    input  logic             id_branch_lt,
    input  logic [1:0]       id_aluop,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             id_alusrc,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rdata1,
    output logic [XLEN-1:0]  ex_rdata2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_branch_eq,
    output logic             ex_branch_ne,
    output logic             ex_branch_lt,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       branch_eq;
        logic       branch_ne;
        logic       branch_lt;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } dat_t;

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    dat_t             dat_q, dat_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    always_comb begin
        load_use = valid_q & ctrl_q.memread & (dat_q.rd != '0) & id_valid &
                   ((dat_q.rd == id_rs1) | (id_uses_rs2 & (dat_q.rd == id_rs2)));
        stall    = load_use & ~flush;
    end

    always_comb begin
        valid_d     = 1'b0;
        ctrl_d      = '0;
        dat_d       = dat_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Bubble keeps the data fields; only valid and control are cleared.
        if (!(flush || load_use || !id_valid)) begin
            valid_d          = 1'b1;
            ctrl_d.branch_eq = id_branch_eq;
            ctrl_d.branch_ne = id_branch_ne;
            ctrl_d.branch_lt = id_branch_lt;
            ctrl_d.memread   = id_memread;
            ctrl_d.memwrite  = id_memwrite;
            ctrl_d.memtoreg  = id_memtoreg;
            ctrl_d.regwrite  = id_regwrite & (id_rd != '0);
            ctrl_d.alusrc    = id_alusrc;
            ctrl_d.aluop     = id_aluop;
            dat_d            = '{pc: id_pc, rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm,
                                 rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && id_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            dat_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            dat_q       <= dat_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = dat_q.pc;
    assign ex_rdata1    = dat_q.rdata1;
    assign ex_rdata2    = dat_q.rdata2;
    assign ex_imm       = dat_q.imm;
    assign ex_rs1       = dat_q.rs1;
    assign ex_rs2       = dat_q.rs2;
    assign ex_rd        = dat_q.rd;
    assign ex_branch_eq = ctrl_q.branch_eq;
    assign ex_branch_ne = ctrl_q.branch_ne;
    assign ex_branch_lt = ctrl_q.branch_lt;
    assign ex_memread   = ctrl_q.memread;
    assign ex_memwrite  = ctrl_q.memwrite;
    assign ex_memtoreg  = ctrl_q.memtoreg;
    assign ex_regwrite  = ctrl_q.regwrite;
    assign ex_alusrc    = ctrl_q.alusrc;
    assign ex_aluop     = ctrl_q.aluop;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized instruction stream against a reference model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_id_ex_stage;

    typedef struct {
        logic        valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        urs2, beq, bne, blt, mr, mw, mtr, rw, as;
        logic [1:0]  aluop;
    } inst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        id_valid, id_uses_rs2, flush;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_branch_eq, id_branch_ne, id_branch_lt;
    logic [1:0]  id_aluop;
    logic        id_memread, id_memwrite, id_memtoreg, id_regwrite, id_alusrc;

    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_branch_eq, ex_branch_ne, ex_branch_lt, ex_memread, ex_memwrite;
    logic        ex_memtoreg, ex_regwrite, ex_alusrc;
    logic [1:0]  ex_aluop;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_rdata1, s_ex_rdata2, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic        s_ex_branch_eq, s_ex_branch_ne, s_ex_branch_lt, s_ex_memread, s_ex_memwrite;
    logic        s_ex_memtoreg, s_ex_regwrite, s_ex_alusrc;
    logic [1:0]  s_ex_aluop;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne), .id_branch_lt(id_branch_lt),
        .id_aluop(id_aluop), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_alusrc(id_alusrc),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne), .ex_branch_lt(ex_branch_lt),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne), .id_branch_lt(id_branch_lt),
        .id_aluop(id_aluop), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_alusrc(id_alusrc),
        .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_rdata1(s_ex_rdata1), .ex_rdata2(s_ex_rdata2), .ex_imm(s_ex_imm),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_branch_eq(s_ex_branch_eq), .ex_branch_ne(s_ex_branch_ne), .ex_branch_lt(s_ex_branch_lt),
        .ex_memread(s_ex_memread), .ex_memwrite(s_ex_memwrite), .ex_memtoreg(s_ex_memtoreg),
        .ex_regwrite(s_ex_regwrite), .ex_alusrc(s_ex_alusrc), .ex_aluop(s_ex_aluop),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int    checks = 0;
    int    failures = 0;
    inst_t m_ex;
    int    n_stall, n_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic inst_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic urs2, input logic mr, input logic mw, input logic rw,
                                 input logic as, input logic [1:0] aluop, input logic [31:0] imm);
        inst_t i;
        i.valid = 1'b1; i.pc = $urandom & 32'hffff_fffc; i.r1 = $urandom; i.r2 = $urandom;
        i.imm = imm; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.urs2 = urs2;
        i.beq = 1'b0; i.bne = 1'b0; i.blt = 1'b0;
        i.mr = mr; i.mw = mw; i.mtr = mr; i.rw = rw; i.as = as; i.aluop = aluop;
        return i;
    endfunction

    function automatic inst_t rnd();
        inst_t i;
        i.valid = ($urandom_range(0, 7) != 0);
        i.pc = $urandom; i.r1 = $urandom; i.r2 = $urandom; i.imm = $urandom;
        i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3)); i.urs2 = 1'($urandom);
        i.beq = 1'($urandom); i.bne = 1'($urandom); i.blt = 1'($urandom);
        i.mr = ($urandom_range(0, 2) == 0); i.mw = 1'($urandom); i.mtr = 1'($urandom);
        i.rw = 1'($urandom); i.as = 1'($urandom); i.aluop = 2'($urandom);
        return i;
    endfunction

    task automatic model_reset();
        m_ex = '{default: '0};
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic check_ex(input string tag);
        chk({tag, ":valid"}, 32'(ex_valid), 32'(m_ex.valid));
        chk({tag, ":ctrl"}, 32'({ex_branch_eq, ex_branch_ne, ex_branch_lt, ex_memread, ex_memwrite,
                                 ex_memtoreg, ex_regwrite, ex_alusrc, ex_aluop}),
            32'({m_ex.beq, m_ex.bne, m_ex.blt, m_ex.mr, m_ex.mw, m_ex.mtr, m_ex.rw, m_ex.as, m_ex.aluop}));
        if (m_ex.valid) begin
            chk({tag, ":pc"}, ex_pc, m_ex.pc);
            chk({tag, ":rdata1"}, ex_rdata1, m_ex.r1);
            chk({tag, ":rdata2"}, ex_rdata2, m_ex.r2);
            chk({tag, ":imm"}, ex_imm, m_ex.imm);
            chk({tag, ":regs"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'({m_ex.rs1, m_ex.rs2, m_ex.rd}));
        end
        chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(sat(n_stall, 65535)));
        chk({tag, ":flush_cnt"}, 32'(flush_cnt), 32'(sat(n_flush, 65535)));
        chk({tag, ":s_stall_cnt"}, 32'(s_stall_cnt), 32'(sat(n_stall, 3)));
        chk({tag, ":s_flush_cnt"}, 32'(s_flush_cnt), 32'(sat(n_flush, 3)));
    endtask

    task automatic drive(input inst_t i, input logic fl);
        id_valid = i.valid; id_pc = i.pc; id_rdata1 = i.r1; id_rdata2 = i.r2; id_imm = i.imm;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_uses_rs2 = i.urs2;
        id_branch_eq = i.beq; id_branch_ne = i.bne; id_branch_lt = i.blt;
        id_memread = i.mr; id_memwrite = i.mw; id_memtoreg = i.mtr;
        id_regwrite = i.rw; id_alusrc = i.as; id_aluop = i.aluop;
        flush = fl;
    endtask

    // One pipeline cycle: drive ID, check stall, clock, update model, check EX.
    task automatic step(input string tag, input inst_t i, input logic fl, output logic stalled);
        logic hz;
        drive(i, fl);
        #1;
        hz = m_ex.valid && m_ex.mr && (m_ex.rd != 0) && i.valid &&
             ((m_ex.rd == i.rs1) || (i.urs2 && (m_ex.rd == i.rs2)));
        stalled = hz && !fl;
        chk({tag, ":stall"}, 32'(stall), 32'(stalled));
        chk({tag, ":s_stall"}, 32'(s_stall), 32'(stalled));
        @(posedge clk);
        if (stalled) n_stall++;
        if (fl && i.valid) n_flush++;
        if (fl || hz || !i.valid) begin
            m_ex.valid = 0; m_ex.beq = 0; m_ex.bne = 0; m_ex.blt = 0; m_ex.mr = 0;
            m_ex.mw = 0; m_ex.mtr = 0; m_ex.rw = 0; m_ex.as = 0; m_ex.aluop = 0;
        end else begin
            m_ex = i;
            m_ex.rw = i.rw && (i.rd != 0);
        end
        #1;
        check_ex(tag);
        @(negedge clk);
    endtask

    initial begin
        inst_t cur, lw6, add7;
        logic  st;

        model_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #1;
        check_ex("reset");
        chk("reset:stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // addi x5,x0,7
        step("addi", mk(0, 0, 5, 0, 0, 0, 1, 1, 2'b11, 7), 1'b0, st);
        chk("addi:rd", 32'(ex_rd), 32'd5);
        chk("addi:imm", ex_imm, 32'd7);
        chk("addi:aluop", 32'(ex_aluop), 32'd3);
        chk("addi:regwrite", 32'(ex_regwrite), 32'd1);

        // lw x6,0(x1) ; add x7,x6,x2
        lw6  = mk(1, 0, 6, 0, 1, 0, 1, 1, 2'b00, 0);
        add7 = mk(6, 2, 7, 1, 0, 0, 1, 0, 2'b10, 0);
        step("lw6", lw6, 1'b0, st);
        step("lu_stall", add7, 1'b0, st);
        chk("lu_stall:stalled", 32'(st), 32'd1);
        chk("lu_bubble:valid", 32'(ex_valid), 32'd0);
        step("lu_load", add7, 1'b0, st);
        chk("lu_load:stalled", 32'(st), 32'd0);
        chk("lu_load:rs1", 32'(ex_rs1), 32'd6);
        chk("lu_load:stall_cnt", 32'(stall_cnt), 32'd1);

        // rs2 gating: addi x8,x9,6 without rs2 use, then sw x6,0(x9)
        step("lw6b", lw6, 1'b0, st);
        step("rs2_unused", mk(9, 6, 8, 0, 0, 0, 1, 1, 2'b11, 6), 1'b0, st);
        step("lw6c", lw6, 1'b0, st);
        step("rs2_used", mk(9, 6, 0, 1, 0, 1, 0, 1, 2'b00, 0), 1'b0, st);
        chk("rs2_used:stalled", 32'(st), 32'd1);

        // Flush with load-use present
        step("lw6d", lw6, 1'b0, st);
        step("flush_lu", add7, 1'b1, st);
        chk("flush_lu:flush_cnt", 32'(flush_cnt), 32'd1);
        chk("flush_lu:stall_cnt", 32'(stall_cnt), 32'd2);

        // x0 destination and lw x0 producer
        step("rd0", mk(1, 2, 0, 1, 0, 0, 1, 0, 2'b10, 0), 1'b0, st);
        chk("rd0:regwrite", 32'(ex_regwrite), 32'd0);
        step("lw0", mk(1, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0), 1'b0, st);
        step("use_x0", mk(0, 0, 3, 1, 0, 0, 1, 0, 2'b10, 0), 1'b0, st);

        // Five stall cycles: 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            step("sat_lw", lw6, 1'b0, st);
            step("sat_stall", add7, 1'b0, st);
            step("sat_load", add7, 1'b0, st);
        end
        chk("sat:s_stall_cnt", 32'(s_stall_cnt), 32'd3);

        // Randomized stream; a stalled instruction stays in ID
        st = 1'b0;
        cur = rnd();
        for (int k = 0; k < 400; k++) begin
            logic fl;
            if (!st) cur = rnd();
            fl = ($urandom_range(0, 5) == 0);
            step("rand", cur, fl, st);
        end

        // Reset asserted mid-stall
        step("pre_rst_lw", lw6, 1'b0, st);
        drive(add7, 1'b0);
        #1;
        chk("pre_rst:stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_ex("mid_rst");
        chk("mid_rst:stall", 32'(stall), 32'd0);
        chk("mid_rst:s_stall", 32'(s_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", add7, 1'b0, st);
        chk("post_rst:valid", 32'(ex_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, sitting directly downstream of the instruction decoder/control unit.
- Latches decoded control signals, immediate, register operands and PC into the EX stage.
- Detects load-use hazards, producing a stall to the PC/IF-ID and inserting a bubble into EX.
- Applies branch-flush bubbles and keeps saturating stall/flush event counters for debug.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)
RA_W, 5, register address width
CNT_W, 16, width of the stall/flush event counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of the ID instruction
id_rs1, id_rs2, id_rd  in  RA_W each  register fields inst[19:15], inst[24:20], inst[11:7]
id_uses_rs2  in  1  instruction reads rs2 (R-type, branch, store)
id_rdata1, id_rdata2  in  XLEN each  register-file read data
id_imm  in  XLEN  sign-extended immediate from the control unit
id_branch_eq, id_branch_ne, id_branch_lt  in  1 each  branch-type decode
id_aluop  in  2  ALU op class
id_memread, id_memwrite, id_memtoreg, id_regwrite, id_alusrc  in  1 each  control decode
flush  in  1  branch resolved taken; kill the instruction entering EX
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  RA_W each  registered copies (for forwarding)
ex_branch_eq, ex_branch_ne, ex_branch_lt, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_alusrc  out  1 each  registered control
ex_aluop  out  2  registered ALU op class
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: while rst_n=0, every ex_* output, ex_valid and both counters are 0, with no clock required. stall is therefore 0.
- Hazard (combinational):
  - load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
  - stall = load_use & ~flush.
- Each rising edge, in priority order:
  1. flush=1 -> bubble.
  2. load_use=1 -> bubble.
  3. id_valid=0 -> bubble.
  4. Otherwise -> load.
- Bubble:
  - Clears ex_valid and every control bit: branch_*, memread, memwrite, memtoreg, regwrite, alusrc, and aluop=2'b00.
  - Data/address fields (pc, rdata, imm, rs, rd) hold their previous values; their content is don't-care.
- Load:
  - Every ex_* field takes its id_* counterpart and ex_valid=1.
  - Exception: ex_regwrite = id_regwrite & (id_rd != 0), which suppresses x0 writes.
- Latency: one cycle, ID to EX. A stalled instruction stays in ID and re-evaluates next cycle. A load-use stall therefore lasts exactly one cycle, because the bubble clears ex_memread.
- Flush with a simultaneous load_use: flush wins, stall stays 0, and flush_cnt increments while stall_cnt does not.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where flush=1 and id_valid=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-stall: outputs clear immediately and stall drops in the same cycle. After release, the first edge loads normally.
- No internal state other than the EX register and the counters. Back-to-back loads with no dependency never stall.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with EX loaded -> all ex_* outputs, ex_valid, stall_cnt, flush_cnt and stall are 0 before the next edge.
- Plain pass-through: addi x5,x0,7 (id_rd=5, imm=7, aluop=11, alusrc=1, regwrite=1) -> next cycle ex_rd=5, ex_imm=7, ex_aluop=11, ex_regwrite=1, ex_valid=1, stall=0.
- Load-use: lw x6,0(x1) followed by add x7,x6,x2 -> stall=1 for exactly one cycle, EX receives a bubble (ex_valid=0, ex_regwrite=0), then the add loads with ex_rs1=6, stall_cnt=1.
- rs2 gating: lw x6 followed by addi x8,x9,6 with id_rs2 field=6 and id_uses_rs2=0 -> stall=0. The same pattern with sw x6,0(x9) and id_uses_rs2=1 -> stall=1.
- Flush priority: load-use condition present and flush=1 on the same cycle -> stall=0, EX bubble, flush_cnt=1, stall_cnt=0.
- x0 and saturation:
  - Load with id_rd=0, id_regwrite=1 -> ex_regwrite=0.
  - Lw x0 followed by a consumer of x0 -> no stall.
  - With CNT_W=2, force 5 stall cycles -> stall_cnt stays at 3.
